// File: rtl/frame_buffer_dbuf.sv
// Double-buffered frame store between an SD-card pixel loader and a VGA scanout.
// The loader fills the hidden bank in raster order; the display reads the other
// bank through a two-stage pipeline with integer upscaling by right-shift.
// Banks swap only at a display-driven swap request once a full frame is present.
module frame_buffer_dbuf #(
  parameter int               PIX_W    = 16,
  parameter int               H_RES    = 320,
  parameter int               V_RES    = 240,
  parameter int               SCALE_SH = 1,
  parameter logic [PIX_W-1:0] BG_COLOR = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  input  logic [PIX_W-1:0] wr_data,
  output logic             wr_ready,
  input  logic             wr_sof,
  input  logic             swap_req,
  input  logic             rd_en,
  input  logic [9:0]       rd_x,
  input  logic [9:0]       rd_y,
  output logic [PIX_W-1:0] rd_data,
  output logic             rd_valid,
  output logic             frame_done,
  output logic             disp_bank,
  output logic             wr_overflow
);

  localparam int DEPTH = H_RES * V_RES;
  localparam int AW    = $clog2(2 * DEPTH);
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PIX_W-1:0] r_mem [0:2*DEPTH-1];

  // Write-side state
  logic [PW-1:0] r_wr_ptr;
  logic          r_wr_ready;
  logic          r_frame_done;
  logic          r_disp_bank;
  logic          r_wr_overflow;

  // Read pipeline state
  logic          r_s1_valid;
  logic          r_s1_bg;
  logic [AW-1:0] r_s1_addr;
  logic          r_rd_valid;
  logic [PIX_W-1:0] r_rd_data;

  logic          w_swap;
  logic          w_wr_accept;
  logic          w_wr_last;
  logic [PW-1:0] w_wr_idx;
  logic [AW-1:0] w_wr_addr;
  logic [9:0]    w_rd_sx;
  logic [9:0]    w_rd_sy;
  logic          w_rd_oob;
  logic [AW-1:0] w_rd_addr;

  // A swap is only honoured when the hidden bank is complete; it outranks wr_sof,
  // and since wr_ready is low whenever a frame is complete, no pixel slips in.
  assign w_swap      = swap_req & r_frame_done;
  assign w_wr_accept = rst_n & wr_valid & r_wr_ready & ~w_swap;

  // wr_sof retargets the write to pixel 0 in the same cycle it is asserted.
  assign w_wr_idx  = wr_sof ? '0 : r_wr_ptr;
  assign w_wr_last = (w_wr_idx == PW'(DEPTH - 1));
  // The write bank is always the inverse of the displayed bank.
  assign w_wr_addr = (r_disp_bank ? AW'(0) : AW'(DEPTH)) + AW'(w_wr_idx);

  assign w_rd_sx   = rd_x >> SCALE_SH;
  assign w_rd_sy   = rd_y >> SCALE_SH;
  assign w_rd_oob  = (int'(w_rd_sx) >= H_RES) || (int'(w_rd_sy) >= V_RES);
  assign w_rd_addr = (r_disp_bank ? AW'(DEPTH) : AW'(0))
                   + AW'(w_rd_sy) * AW'(H_RES) + AW'(w_rd_sx);

  // Write pointer, handshake, frame-complete flag, bank select and overflow flag.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every always_ff
    // samples the pre-edge values regardless of block evaluation order.
    if (!rst_n) begin
      r_wr_ptr      <= '0;
      r_wr_ready    <= 1'b1;
      r_frame_done  <= 1'b0;
      r_disp_bank   <= 1'b0;
      r_wr_overflow <= 1'b0;
    end else begin
      if (wr_valid && !r_wr_ready) r_wr_overflow <= 1'b1;
      if (w_swap) begin
        r_disp_bank  <= ~r_disp_bank;
        r_frame_done <= 1'b0;
        r_wr_ptr     <= '0;
        r_wr_ready   <= 1'b1;
      end else if (w_wr_accept) begin
        if (w_wr_last) begin
          r_frame_done <= 1'b1;
          r_wr_ready   <= 1'b0;
          r_wr_ptr     <= w_wr_idx;
        end else begin
          r_frame_done <= 1'b0;
          r_wr_ready   <= 1'b1;
          r_wr_ptr     <= w_wr_idx + PW'(1);
        end
      end else if (wr_sof) begin
        r_wr_ptr     <= '0;
        r_frame_done <= 1'b0;
        r_wr_ready   <= 1'b1;
      end
    end
  end

  // Pixel storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the pixel array has no reset; clearing it would need a sweep FSM,
    // prevent block-RAM mapping, and frame contents are meaningless after reset anyway.
    if (w_wr_accept) r_mem[w_wr_addr] <= wr_data;
  end

  // Read stage 1: register the scaled address, bank and out-of-range flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_bg    <= 1'b0;
      r_s1_addr  <= '0;
    end else begin
      r_s1_valid <= rd_en;
      if (rd_en) begin
        r_s1_bg   <= w_rd_oob;
        r_s1_addr <= w_rd_addr;
      end
    end
  end

  // Read stage 2: registered memory read, or background for off-frame pixels.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= r_s1_valid;
      if (r_s1_valid) r_rd_data <= r_s1_bg ? BG_COLOR : r_mem[r_s1_addr];
    end
  end

  assign wr_ready    = r_wr_ready;
  assign frame_done  = r_frame_done;
  assign disp_bank   = r_disp_bank;
  assign wr_overflow = r_wr_overflow;
  assign rd_valid    = r_rd_valid;
  assign rd_data     = r_rd_data;

endmodule

// File: tb/tb_frame_buffer_dbuf.sv
// Directed bench for frame_buffer_dbuf with a 4x2 frame and 2x upscale.
// Read expectations go into a queue; a negedge monitor pops and compares them
// (data and latency) whenever rd_valid is seen. Status flags are checked inline.
module tb_frame_buffer_dbuf;

  localparam int          PIX_W = 16;
  localparam logic [15:0] BG    = 16'hBEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic [15:0] wr_data = '0;
  logic        wr_ready;
  logic        wr_sof = 1'b0;
  logic        swap_req = 1'b0;
  logic        rd_en = 1'b0;
  logic [9:0]  rd_x = '0;
  logic [9:0]  rd_y = '0;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        frame_done;
  logic        disp_bank;
  logic        wr_overflow;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  frame_buffer_dbuf #(
    .PIX_W(PIX_W), .H_RES(4), .V_RES(2), .SCALE_SH(1), .BG_COLOR(BG)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready), .wr_sof(wr_sof),
    .swap_req(swap_req), .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y),
    .rd_data(rd_data), .rd_valid(rd_valid), .frame_done(frame_done),
    .disp_bank(disp_bank), .wr_overflow(wr_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every rd_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        check("rd_unexpected", 32'(rd_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rd_data", 32'(rd_data), 32'(mon_e.data));
        check("rd_latency", cyc, mon_e.due);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_px(input logic [15:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic wr_stream(input logic [15:0] first, input int n);
    for (int i = 0; i < n; i++) wr_px(first + 16'(i));
  endtask

  task automatic do_swap();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
  endtask

  task automatic rd(input logic [9:0] x, input logic [9:0] y, input logic [15:0] e);
    rd_en = 1'b1;
    rd_x  = x;
    rd_y  = y;
    exp_q.push_back('{data: e, due: cyc + 2});
    tick();
    rd_en = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic rdy, input logic done,
                              input logic bank);
    check({tag, "_wr_ready"}, 32'(wr_ready), 32'(rdy));
    check({tag, "_frame_done"}, 32'(frame_done), 32'(done));
    check({tag, "_disp_bank"}, 32'(disp_bank), 32'(bank));
  endtask

  task automatic check_reset_state(input string tag);
    check_status(tag, 1'b1, 1'b0, 1'b0);
    check({tag, "_overflow"}, 32'(wr_overflow), 32'd0);
    check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    check({tag, "_rd_data"}, 32'(rd_data), 32'd0);
  endtask

  initial begin
    // Reset
    tick();
    tick();
    rst_n = 1'b1;
    check_reset_state("reset");

    // Fill bank 1, swap, read back with upscaling and out-of-range coordinates
    wr_stream(16'h0001, 7);
    check_status("fill7", 1'b1, 1'b0, 1'b0);
    wr_px(16'h0008);
    check_status("fill8", 1'b0, 1'b1, 1'b0);
    do_swap();
    check_status("swap1", 1'b1, 1'b0, 1'b1);
    rd(10'd2, 10'd2, 16'h0006);
    rd(10'd0, 10'd0, 16'h0001);
    rd(10'd7, 10'd3, 16'h0008);
    rd(10'd6, 10'd0, 16'h0004);
    rd(10'd8, 10'd0, BG);
    rd(10'd0, 10'd4, BG);
    tick(); tick(); tick();
    check("rd_hold_valid", 32'(rd_valid), 32'd0);
    check("rd_hold_data", 32'(rd_data), 32'(BG));

    // Overflow: fill bank 0, keep pushing, then swap with sof+valid in same cycle
    wr_stream(16'h0011, 8);
    check_status("fill_b0", 1'b0, 1'b1, 1'b1);
    wr_valid = 1'b1;
    wr_data  = 16'h00FF;
    tick();
    tick();
    check("ovf_set", 32'(wr_overflow), 32'd1);
    check("ovf_ready", 32'(wr_ready), 32'd0);
    swap_req = 1'b1;
    wr_sof   = 1'b1;
    wr_data  = 16'h00EE;
    tick();
    swap_req = 1'b0;
    wr_sof   = 1'b0;
    wr_valid = 1'b0;
    check_status("swap2", 1'b1, 1'b0, 1'b0);
    check("ovf_sticky", 32'(wr_overflow), 32'd1);
    rd(10'd0, 10'd0, 16'h0011);
    rd(10'd7, 10'd3, 16'h0018);
    rd(10'd4, 10'd2, 16'h0017);
    // The pixel offered in the swap cycle must not have been taken
    wr_stream(16'h0021, 7);
    check("swap_drop_done7", 32'(frame_done), 32'd0);
    wr_px(16'h0028);
    check("swap_drop_done8", 32'(frame_done), 32'd1);

    // Swap ignored on a partial frame
    do_swap();
    check_status("swap3", 1'b1, 1'b0, 1'b1);
    wr_stream(16'h0031, 5);
    do_swap();
    check_status("partial_swap", 1'b1, 1'b0, 1'b1);
    rd(10'd0, 10'd0, 16'h0021);
    wr_stream(16'h0036, 3);
    check_status("partial_done", 1'b0, 1'b1, 1'b1);
    // Read issued in the swap cycle still sees the old bank
    rd_en    = 1'b1;
    rd_x     = 10'd0;
    rd_y     = 10'd0;
    swap_req = 1'b1;
    exp_q.push_back('{data: 16'h0021, due: cyc + 2});
    tick();
    swap_req = 1'b0;
    rd(10'd0, 10'd0, 16'h0031);
    rd(10'd4, 10'd0, 16'h0033);
    rd(10'd6, 10'd2, 16'h0038);
    check("swap4_bank", 32'(disp_bank), 32'd0);

    // wr_sof mid-frame with a pixel in the same cycle
    wr_stream(16'h0041, 3);
    wr_valid = 1'b1;
    wr_sof   = 1'b1;
    wr_data  = 16'h00AA;
    tick();
    wr_valid = 1'b0;
    wr_sof   = 1'b0;
    check_status("sof", 1'b1, 1'b0, 1'b0);
    wr_stream(16'h0051, 6);
    check("sof_done6", 32'(frame_done), 32'd0);
    wr_px(16'h0057);
    check("sof_done7", 32'(frame_done), 32'd1);
    do_swap();
    check("swap5_bank", 32'(disp_bank), 32'd1);
    rd(10'd0, 10'd0, 16'h00AA);
    rd(10'd2, 10'd0, 16'h0051);
    rd(10'd4, 10'd0, 16'h0052);
    rd(10'd6, 10'd2, 16'h0057);
    tick(); tick(); tick();

    // Reset mid-frame with a read in flight
    wr_stream(16'h0061, 3);
    rd_en = 1'b1;
    rd_x  = 10'd0;
    rd_y  = 10'd0;
    tick();
    rd_en = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_reset_state("midreset");
    tick();
    check("midreset_flush", 32'(rd_valid), 32'd0);
    rd(10'd0, 10'd0, 16'h0061);
    wr_stream(16'h0071, 8);
    check_status("post_reset_fill", 1'b0, 1'b1, 1'b0);
    do_swap();
    rd(10'd0, 10'd0, 16'h0071);
    rd(10'd6, 10'd2, 16'h0078);

    // Drain outstanding reads within a bounded window
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick();
    check("queue_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/frame_buffer_dbuf.md
FRAME_BUFFER_DBUF -- requirements
Module: frame_buffer_dbuf

Interface
REQ-001 SHALL have parameter PIX_W, default 16, bits per pixel.
REQ-002 SHALL have parameter H_RES, default 320, stored frame width in pixels.
REQ-003 SHALL have parameter V_RES, default 240, stored frame height in lines.
REQ-004 SHALL have parameter SCALE_SH, default 1, read-coordinate right-shift (1 = 2x upscale to 640x480).
REQ-005 SHALL have parameter BG_COLOR, default 16'h0000, pixel returned for out-of-range reads.
REQ-006 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-008 SHALL have port wr_valid  input  1  loader presents a pixel.
REQ-009 SHALL have port wr_data  input  PIX_W  pixel from SD loader, raster order.
REQ-010 SHALL have port wr_ready  output  1  buffer accepts a pixel this cycle.
REQ-011 SHALL have port wr_sof  input  1  pulse, restart write frame at pixel 0.
REQ-012 SHALL have port swap_req  input  1  pulse, display requests bank swap (driven at vsync).
REQ-013 SHALL have port rd_en  input  1  display read request.
REQ-014 SHALL have port rd_x  input  10  display column.
REQ-015 SHALL have port rd_y  input  10  display row.
REQ-016 SHALL have port rd_data  output  PIX_W  pixel to VGA.
REQ-017 SHALL have port rd_valid  output  1  rd_data valid.
REQ-018 SHALL have port frame_done  output  1  write bank holds a complete frame.
REQ-019 SHALL have port disp_bank  output  1  bank currently displayed; write bank is its inverse.
REQ-020 SHALL have port wr_overflow  output  1  sticky, wr_valid seen while wr_ready=0.

Function
REQ-021 SHALL hold 2 x H_RES*V_RES words of PIX_W; bank b occupies [b*H_RES*V_RES, (b+1)*H_RES*V_RES-1].
REQ-022 SHALL write wr_data at address wr_ptr of write bank when wr_valid & wr_ready, then wr_ptr += 1.
REQ-023 SHALL, on accepted write with wr_ptr = H_RES*V_RES-1, set frame_done=1 and wr_ready=0 next cycle; wr_ptr holds.
REQ-024 SHALL, when wr_sof=1 and swap not taken, set wr_ptr=0 and frame_done=0, wr_ready=1; if wr_valid same cycle, write address 0 and wr_ptr becomes 1.
REQ-025 SHALL, on swap_req=1 with frame_done=1, toggle disp_bank, clear frame_done, set wr_ptr=0, wr_ready=1 next cycle.
REQ-026 SHALL ignore swap_req when frame_done=0 (no toggle, partial frame kept, display unaffected).
REQ-027 SHALL give swap priority over wr_sof when both asserted with frame_done=1; wr_valid that cycle is not accepted (wr_ready=0).
REQ-028 SHALL set wr_overflow=1 on any cycle wr_valid=1 & wr_ready=0; cleared only by reset; offending pixel dropped.
REQ-029 SHALL compute read coordinates sx=rd_x>>SCALE_SH, sy=rd_y>>SCALE_SH, address = disp_bank*H_RES*V_RES + sy*H_RES + sx.
REQ-030 SHALL return rd_data with fixed 2-cycle latency from rd_en (stage 1 address register, stage 2 memory register); rd_valid is rd_en delayed 2 cycles.
REQ-031 SHALL return BG_COLOR when sx >= H_RES or sy >= V_RES; no memory access for that request.
REQ-032 SHALL sample disp_bank in read stage 1; a swap mid-pipeline affects only requests issued after the swap edge.
REQ-033 SHALL update rd_data only when a stage-2 request is valid; otherwise hold.
REQ-034 SHALL never write the displayed bank.

Reset
REQ-035 SHALL, while rst_n=0 at a clock edge: wr_ptr=0, wr_ready=1, frame_done=0, disp_bank=0, wr_overflow=0, rd_valid=0, rd_data=0, read pipeline flushed.
REQ-036 SHALL not clear memory contents on reset.
REQ-037 SHALL drop a mid-frame write or in-flight read on reset; writing restarts at pixel 0 of bank 1.

Verification (H_RES=4, V_RES=2, SCALE_SH=1)
REQ-038 SHALL: reset, stream 8 pixels 0x0001..0x0008 -> wr_ready=0 and frame_done=1 one cycle after the 8th; swap_req -> disp_bank=1; read (rd_x=2,rd_y=2) -> rd_data=0x0006, rd_valid 2 cycles after rd_en.
REQ-039 SHALL: swap_req after 5 of 8 pixels -> disp_bank unchanged, frame_done=0, remaining 3 pixels accepted.
REQ-040 SHALL: wr_valid held after frame full -> wr_overflow=1, memory at bank addresses unchanged.
REQ-041 SHALL: rd_x=8, rd_y=0 -> rd_data=BG_COLOR after 2 cycles.
REQ-042 SHALL: wr_sof after 3 pixels with new pixel 0x00AA -> address 0 of write bank =0x00AA, wr_ptr=1, frame_done=0.
REQ-043 SHALL: rst_n=0 mid-frame for one cycle -> all outputs at REQ-035 values next cycle, next write lands at bank 1 address 0.
